// File: rtl/cpu_attack_sequencer_pkg.sv
// Shared encodings for the CPU attack sequencer: attack types, phase codes,
// the duration table and the (phase, type) -> duration lookup.
package cpu_pkg;

  // Attack types as produced by the random generator; 2'b11 is treated as STANDBY.
  typedef enum logic [1:0] {
    ATK_STANDBY = 2'b00,
    ATK_LIGHT   = 2'b01,
    ATK_HEAVY   = 2'b10
  } atk_e;

  // Phase codes, also driven out on o_phase.
  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_DECIDE  = 3'd1,
    PH_WINDUP  = 3'd2,
    PH_ACTIVE  = 3'd3,
    PH_RECOVER = 3'd4
  } phase_e;

  // Phase durations in game ticks; the top fills this from its parameters.
  typedef struct packed {
    logic [15:0] idle;
    logic [15:0] light_windup;
    logic [15:0] heavy_windup;
    logic [15:0] light_active;
    logic [15:0] heavy_active;
    logic [15:0] light_recover;
    logic [15:0] heavy_recover;
  } dur_cfg_t;

  // Duration of a timed phase for the given attack type. DECIDE is untimed
  // and falls into the IDLE entry, which is never used for it.
  function automatic logic [15:0] phase_dur(input phase_e ph, input logic [1:0] typ,
                                            input dur_cfg_t cfg);
    logic heavy;
    heavy = (typ == ATK_HEAVY);
    case (ph)
      PH_WINDUP:  return heavy ? cfg.heavy_windup  : cfg.light_windup;
      PH_ACTIVE:  return heavy ? cfg.heavy_active  : cfg.light_active;
      PH_RECOVER: return heavy ? cfg.heavy_recover : cfg.light_recover;
      default:    return cfg.idle;
    endcase
  endfunction

endpackage

// File: rtl/cpu_attack_sequencer_phase_timer.sv
// Phase down-counter: loads a duration, decrements on game ticks and flags
// expiry on the tick where the count is 1. It never goes below 1.
module phase_timer #(
  parameter int              CNT_W   = 4,
  parameter logic [CNT_W-1:0] RST_VAL = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over the decrement; the count holds at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_tick && (cnt_q > CNT_W'(1))) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

  assign o_expire = i_tick && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cpu_attack_sequencer.sv
// CPU attack sequencer: IDLE -> DECIDE -> WINDUP -> ACTIVE -> RECOVER, timed
// in game ticks, offering one strike per attack to the combat resolver.
// Optional macro CPU_STRIKE_STATS_EN adds o_strike_cnt, a saturating count of
// accepted strikes cleared only by i_reset.
//
// Strike handshake: o_strike_valid rises on entry to ACTIVE and holds with a
// stable o_strike_type until the cycle where o_strike_valid & i_strike_ready,
// which is the single transfer; valid then stays low for the rest of ACTIVE.
// If ACTIVE expires first, valid falls on leaving ACTIVE and the strike is lost.
module cpu_attack_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W         = 4,
  parameter int IDLE_TICKS    = 4,
  parameter int LIGHT_WINDUP  = 2,
  parameter int HEAVY_WINDUP  = 6,
  parameter int LIGHT_ACTIVE  = 1,
  parameter int HEAVY_ACTIVE  = 2,
  parameter int LIGHT_RECOVER = 3,
  parameter int HEAVY_RECOVER = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_tick,
  input  logic [1:0] i_cpu_type,
  input  logic       i_interrupt,
  input  logic       i_strike_ready,
  output logic [2:0] o_phase,
  output logic [1:0] o_attack_type,
  output logic       o_windup,
  output logic       o_strike_valid,
  output logic [1:0] o_strike_type
`ifdef CPU_STRIKE_STATS_EN
  ,
  output logic [7:0] o_strike_cnt
`endif
);

  localparam dur_cfg_t DUR = '{
    idle:          16'(IDLE_TICKS),
    light_windup:  16'(LIGHT_WINDUP),
    heavy_windup:  16'(HEAVY_WINDUP),
    light_active:  16'(LIGHT_ACTIVE),
    heavy_active:  16'(HEAVY_ACTIVE),
    light_recover: 16'(LIGHT_RECOVER),
    heavy_recover: 16'(HEAVY_RECOVER)
  };

  phase_e     phase_q, phase_d;
  logic [1:0] type_q, type_d;
  logic       valid_q, valid_d;

  logic             load;
  phase_e           load_ph;
  logic [1:0]       load_type;
  logic [CNT_W-1:0] load_val;
  logic             tick_en;
  logic             expire;
  logic             handshake;

  assign handshake = valid_q && i_strike_ready;
  // DECIDE is a single clock and must not consume a tick.
  assign tick_en   = i_tick && (phase_q != PH_DECIDE);
  assign load_val  = CNT_W'(phase_dur(load_ph, load_type, DUR));

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(IDLE_TICKS))
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (load),
    .i_load_val (load_val),
    .i_tick     (tick_en),
    .o_expire   (expire)
  );

  // Next phase, latched type, strike valid and timer load; the disable
  // override outranks interrupt, which outranks expiry.
  always_comb begin
    phase_d   = phase_q;
    type_d    = type_q;
    valid_d   = valid_q;
    load      = 1'b0;
    load_ph   = PH_IDLE;
    load_type = type_q;
    if (!i_enable) begin
      phase_d = PH_IDLE;
      type_d  = ATK_STANDBY;
      valid_d = 1'b0;
      load    = 1'b1;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          if (expire) phase_d = PH_DECIDE;
        end
        PH_DECIDE: begin
          load = 1'b1;
          if ((i_cpu_type == ATK_LIGHT) || (i_cpu_type == ATK_HEAVY)) begin
            phase_d   = PH_WINDUP;
            type_d    = i_cpu_type;
            load_ph   = PH_WINDUP;
            load_type = i_cpu_type;
          end else begin
            phase_d = PH_IDLE;
            type_d  = ATK_STANDBY;
          end
        end
        PH_WINDUP: begin
          if (i_interrupt) begin
            phase_d = PH_RECOVER;
            load    = 1'b1;
            load_ph = PH_RECOVER;
          end else if (expire) begin
            phase_d = PH_ACTIVE;
            valid_d = 1'b1;
            load    = 1'b1;
            load_ph = PH_ACTIVE;
          end
        end
        PH_ACTIVE: begin
          if (handshake) valid_d = 1'b0;
          if (expire) begin
            phase_d = PH_RECOVER;
            valid_d = 1'b0;
            load    = 1'b1;
            load_ph = PH_RECOVER;
          end
        end
        PH_RECOVER: begin
          if (expire) begin
            phase_d = PH_IDLE;
            type_d  = ATK_STANDBY;
            load    = 1'b1;
          end
        end
        default: begin
          phase_d = PH_IDLE;
          type_d  = ATK_STANDBY;
          valid_d = 1'b0;
          load    = 1'b1;
        end
      endcase
    end
  end

  // Phase, latched type and strike-valid registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase_q <= PH_IDLE;
      type_q  <= ATK_STANDBY;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      type_q  <= type_d;
      valid_q <= valid_d;
    end
  end

  assign o_phase        = phase_q;
  assign o_attack_type  = ((phase_q == PH_WINDUP) || (phase_q == PH_ACTIVE) ||
                           (phase_q == PH_RECOVER)) ? type_q : ATK_STANDBY;
  assign o_windup       = (phase_q == PH_WINDUP);
  assign o_strike_valid = valid_q;
  assign o_strike_type  = o_attack_type;

`ifdef CPU_STRIKE_STATS_EN
  logic [7:0] strike_cnt_q, strike_cnt_d;

  // Saturating count of accepted strikes.
  always_comb begin
    strike_cnt_d = strike_cnt_q;
    if (handshake && (strike_cnt_q != 8'hff)) strike_cnt_d = strike_cnt_q + 8'd1;
  end

  // Strike counter register; survives i_enable going low.
  always_ff @(posedge i_clk) begin
    if (i_reset) strike_cnt_q <= 8'd0;
    else         strike_cnt_q <= strike_cnt_d;
  end

  assign o_strike_cnt = strike_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_attack_sequencer.sv
// Directed bench for cpu_attack_sequencer (default parameters). Optional
// macro CPU_STRIKE_STATS_EN enables the strike-counter checks.
module tb_cpu_attack_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       tick;
  logic [1:0] typ;
  logic       intr;
  logic       rdy;
  logic [2:0] o_phase;
  logic [1:0] o_attack_type;
  logic       o_windup;
  logic       o_strike_valid;
  logic [1:0] o_strike_type;
`ifdef CPU_STRIKE_STATS_EN
  logic [7:0] o_strike_cnt;
`endif

  int checks;
  int errors;
  int tick_cnt;
  logic tick_slow;

  localparam logic [2:0] IDL = 3'd0, DEC = 3'd1, WND = 3'd2, ACT = 3'd3, REC = 3'd4;

  cpu_attack_sequencer dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_enable       (en),
    .i_tick         (tick),
    .i_cpu_type     (typ),
    .i_interrupt    (intr),
    .i_strike_ready (rdy),
    .o_phase        (o_phase),
    .o_attack_type  (o_attack_type),
    .o_windup       (o_windup),
    .o_strike_valid (o_strike_valid),
    .o_strike_type  (o_strike_type)
`ifdef CPU_STRIKE_STATS_EN
    ,
    .o_strike_cnt   (o_strike_cnt)
`endif
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (tick_slow) begin
      tick_cnt++;
      tick = (tick_cnt % 4 == 0);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step n clocks, expecting {phase, attack type, windup, valid, strike type} each clock.
  task automatic seq(input string tag, input int n, input logic [2:0] ph, input logic [1:0] ty,
                     input logic w, input logic v);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s[%0d]", tag, i),
          {7'd0, o_phase, o_attack_type, o_windup, o_strike_valid, o_strike_type},
          {7'd0, ph, ty, w, v, ty});
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
`ifdef CPU_STRIKE_STATS_EN
    chk(tag, {8'd0, o_strike_cnt}, {8'd0, exp});
`else
    if (exp == 8'hee) $display("unused %s", tag);
`endif
  endtask

  initial begin
    checks = 0; errors = 0; tick_cnt = 0; tick_slow = 1'b0;
    rst = 1'b1; en = 1'b1; tick = 1'b1; typ = 2'b01; intr = 1'b0; rdy = 1'b1;
    step();
    step();
    chk("reset_state", {7'd0, o_phase, o_attack_type, o_windup, o_strike_valid, o_strike_type}, 16'd0);
    chk_cnt("reset_cnt", 8'd0);
    rst = 1'b0;

    // LIGHT with tick every clock: this clock is IDLE clock 1.
    seq("t1_idle", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t1_decide", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t1_windup", 2, WND, 2'b01, 1'b1, 1'b0);
    seq("t1_active", 1, ACT, 2'b01, 1'b0, 1'b1);
    seq("t1_recover", 3, REC, 2'b01, 1'b0, 1'b0);
    seq("t1_idle_back", 1, IDL, 2'b00, 1'b0, 1'b0);

    // STANDBY then 2'b11: straight back to IDLE, decisions every 5 clocks.
    typ = 2'b00;
    seq("t2_idle_a", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t2_decide_a", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t2_idle_b0", 1, IDL, 2'b00, 1'b0, 1'b0);
    typ = 2'b11;
    seq("t2_idle_b", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t2_decide_b", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t2_idle_c0", 1, IDL, 2'b00, 1'b0, 1'b0);
    typ = 2'b10; rdy = 1'b0;
    seq("t2_idle_c", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t3_decide", 1, DEC, 2'b00, 1'b0, 1'b0);

    // HEAVY, resolver never ready: valid for both ACTIVE clocks, then dropped.
    seq("t3_windup", 6, WND, 2'b10, 1'b1, 1'b0);
    seq("t3_active", 2, ACT, 2'b10, 1'b0, 1'b1);
    seq("t3_recover", 8, REC, 2'b10, 1'b0, 1'b0);
    seq("t3_idle", 1, IDL, 2'b00, 1'b0, 1'b0);
    chk_cnt("t3_cnt", 8'd1);

    // HEAVY, interrupt on the 3rd WINDUP clock cancels into an 8-clock RECOVER.
    seq("t4_idle", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t4_decide", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t4_windup", 3, WND, 2'b10, 1'b1, 1'b0);
    intr = 1'b1;
    seq("t4_int_recover", 1, REC, 2'b10, 1'b0, 1'b0);
    intr = 1'b0;
    seq("t4_recover", 7, REC, 2'b10, 1'b0, 1'b0);
    seq("t4_idle_back", 1, IDL, 2'b00, 1'b0, 1'b0);

    // Interrupt during ACTIVE is ignored; handshake on the expiry clock is accepted.
    seq("t4b_idle", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t4b_decide", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t4b_windup", 6, WND, 2'b10, 1'b1, 1'b0);
    seq("t4b_active1", 1, ACT, 2'b10, 1'b0, 1'b1);
    intr = 1'b1;
    seq("t4b_active2", 1, ACT, 2'b10, 1'b0, 1'b1);
    intr = 1'b0; rdy = 1'b1;
    seq("t4b_recover1", 1, REC, 2'b10, 1'b0, 1'b0);
    rdy = 1'b0;
    seq("t4b_recover", 7, REC, 2'b10, 1'b0, 1'b0);
    seq("t4b_idle_back", 1, IDL, 2'b00, 1'b0, 1'b0);
    chk_cnt("t4b_cnt", 8'd2);

    // Disable mid-ACTIVE with valid high; re-enable restarts the 4-tick IDLE.
    seq("t5_idle", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t5_decide", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t5_windup", 6, WND, 2'b10, 1'b1, 1'b0);
    seq("t5_active", 1, ACT, 2'b10, 1'b0, 1'b1);
    en = 1'b0;
    seq("t5_disabled", 3, IDL, 2'b00, 1'b0, 1'b0);
    en = 1'b1;
    seq("t5_idle_re", 3, IDL, 2'b00, 1'b0, 1'b0);
    seq("t5_decide_re", 1, DEC, 2'b00, 1'b0, 1'b0);
    rdy = 1'b1;
    // Early handshake: valid drops for the second ACTIVE clock.
    seq("t5_windup_re", 6, WND, 2'b10, 1'b1, 1'b0);
    seq("t5_active_hs", 1, ACT, 2'b10, 1'b0, 1'b1);
    seq("t5_active_after", 1, ACT, 2'b10, 1'b0, 1'b0);
    seq("t5_recover", 8, REC, 2'b10, 1'b0, 1'b0);
    seq("t5_idle_back", 1, IDL, 2'b00, 1'b0, 1'b0);
    chk_cnt("t5_cnt", 8'd3);

    // LIGHT with a tick every 4th clock (ticks fall on c4, c8, ...). Each tick-timed
    // span is 4 clocks per tick, except WINDUP, which starts right after the
    // one-clock DECIDE and so spans 7 clocks (c18..c24).
    en = 1'b0; typ = 2'b01;
    seq("t6_disabled", 1, IDL, 2'b00, 1'b0, 1'b0);
    en = 1'b1; tick_slow = 1'b1; tick_cnt = 0; tick = 1'b0;
    seq("t6_idle", 16, IDL, 2'b00, 1'b0, 1'b0);
    seq("t6_decide", 1, DEC, 2'b00, 1'b0, 1'b0);
    seq("t6_windup", 7, WND, 2'b01, 1'b1, 1'b0);
    seq("t6_active_hs", 1, ACT, 2'b01, 1'b0, 1'b1);
    seq("t6_active_after", 3, ACT, 2'b01, 1'b0, 1'b0);
    seq("t6_recover", 12, REC, 2'b01, 1'b0, 1'b0);
    seq("t6_idle_back", 1, IDL, 2'b00, 1'b0, 1'b0);
    chk_cnt("t6_cnt", 8'd4);

`ifdef CPU_STRIKE_STATS_EN
    // Over 300 LIGHT strikes (11 clocks each) saturate the counter.
    tick_slow = 1'b0; tick = 1'b1;
    for (int i = 0; i < 3400; i++) step();
    chk_cnt("stats_saturate", 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
